// File: rtl/frame_scan_ctrl.sv
// Raster address sequencer for one LCD frame of the Pong display.
// Window-setup handshake, then X/Y stepping on each accepted pixel.
module frame_scan_ctrl #(
  parameter int X_LAST = 239,
  parameter int Y_LAST = 319,
  parameter int X_W    = 8,
  parameter int Y_W    = 9
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  output logic           win_req,
  input  logic           win_ack,
  output logic           pixel_valid,
  input  logic           pixel_ready,
  output logic [X_W-1:0] x_addr,
  output logic [Y_W-1:0] y_addr,
  output logic           line_start,
  output logic           frame_start,
  output logic           busy,
  output logic           frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    WIN,
    SCAN,
    DONE
  } state_t;

  localparam logic [X_W-1:0] XL = X_W'(X_LAST);
  localparam logic [Y_W-1:0] YL = Y_W'(Y_LAST);

  state_t         state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           win_q, win_d;
  logic           pv_q, pv_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           xfer;

  assign xfer = pv_q & pixel_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      win_q   <= 1'b0;
      pv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      win_q   <= win_d;
      pv_q    <= pv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    win_d   = win_q;
    pv_d    = pv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        x_d = '0;
        y_d = '0;
        if (start && !abort) begin
          state_d = WIN;
          win_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      WIN: begin
        if (abort) begin
          state_d = IDLE;
          win_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (win_ack) begin
          state_d = SCAN;
          win_d   = 1'b0;
          pv_d    = 1'b1;
          x_d     = '0;
          y_d     = '0;
        end
      end
      SCAN: begin
        // abort outranks a transfer in the same cycle
        if (abort) begin
          state_d = IDLE;
          pv_d    = 1'b0;
          busy_d  = 1'b0;
          x_d     = '0;
          y_d     = '0;
        end else if (xfer) begin
          if (x_q != XL) begin
            x_d = x_q + X_W'(1);
          end else if (y_q != YL) begin
            x_d = '0;
            y_d = y_q + Y_W'(1);
          end else begin
            state_d = DONE;
            pv_d    = 1'b0;
            done_d  = 1'b1;
            x_d     = '0;
            y_d     = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        win_d   = 1'b0;
        pv_d    = 1'b0;
        busy_d  = 1'b0;
        x_d     = '0;
        y_d     = '0;
      end
    endcase
  end

  assign win_req     = win_q;
  assign pixel_valid = pv_q;
  assign x_addr      = x_q;
  assign y_addr      = y_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign line_start  = pv_q && (x_q == '0);
  assign frame_start = pv_q && (x_q == '0) && (y_q == '0);

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// Directed bench: small 4x3 frame instance plus a default-size instance.
// Expected values come from hand-derived raster sequences.
module tb_frame_scan_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       win_ack = 1'b0;
  logic       pixel_ready = 1'b0;
  logic       win_req, pixel_valid, line_start, frame_start, busy, frame_done;
  logic [1:0] x_addr, y_addr;

  logic       start2 = 1'b0;
  logic       abort2 = 1'b0;
  logic       ack2 = 1'b0;
  logic       ready2 = 1'b1;
  logic       win2, pv2, ls2, fs2, busy2, done2;
  logic [7:0] x2;
  logic [8:0] y2;

  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  frame_scan_ctrl #(.X_LAST(3), .Y_LAST(2), .X_W(2), .Y_W(2)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .win_req(win_req), .win_ack(win_ack),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .x_addr(x_addr), .y_addr(y_addr),
    .line_start(line_start), .frame_start(frame_start),
    .busy(busy), .frame_done(frame_done)
  );

  frame_scan_ctrl dut_big (
    .clock(clock), .reset(reset), .start(start2), .abort(abort2),
    .win_req(win2), .win_ack(ack2),
    .pixel_valid(pv2), .pixel_ready(ready2),
    .x_addr(x2), .y_addr(y2),
    .line_start(ls2), .frame_start(fs2),
    .busy(busy2), .frame_done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic begin_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    win_ack = 1'b1;
    step();
    win_ack = 1'b0;
  endtask

  initial begin
    int ex, ey, nx, cyc, dn, maxx, lx, ly;

    // reset state
    #1;
    chk("rst_win", win_req, 0);
    chk("rst_pv", pixel_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_x", x_addr, 0);
    chk("rst_y", y_addr, 0);
    step();
    reset = 1'b0;
    step();

    // test 1: full frame, ready held high
    pixel_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_winreq", win_req, 1);
    chk("t1_busy", busy, 1);
    win_ack = 1'b1;
    step();
    win_ack = 1'b0;
    chk("t1_winreq_off", win_req, 0);
    chk("t1_pv", pixel_valid, 1);
    for (int i = 0; i < 12; i++) begin
      chk("t1_x", x_addr, i % 4);
      chk("t1_y", y_addr, i / 4);
      chk("t1_ls", line_start, (i % 4) == 0);
      chk("t1_fs", frame_start, i == 0);
      chk("t1_nodone", frame_done, 0);
      step();
    end
    chk("t1_done", frame_done, 1);
    chk("t1_busy_done", busy, 1);
    chk("t1_pv_off", pixel_valid, 0);
    chk("t1_x0", x_addr, 0);
    step();
    chk("t1_done_off", frame_done, 0);
    chk("t1_idle", busy, 0);

    // test 2: random stalls, win_ack delayed 5 cycles
    pixel_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_winreq_hold", win_req, 1);
      chk("t2_pv_wait", pixel_valid, 0);
      step();
    end
    win_ack = 1'b1;
    step();
    win_ack = 1'b0;
    ex = 0; ey = 0; nx = 0; cyc = 0; dn = 0;
    while (nx < 12 && cyc < 300) begin
      pixel_ready = 1'($urandom % 2);
      chk("t2_x", x_addr, ex);
      chk("t2_y", y_addr, ey);
      chk("t2_pv", pixel_valid, 1);
      if (frame_done) dn++;
      if (pixel_ready) begin
        nx++;
        if (ex == 3) begin ex = 0; ey++; end
        else ex++;
      end
      step();
      cyc++;
    end
    pixel_ready = 1'b0;
    chk("t2_xfers", nx, 12);
    chk("t2_done", frame_done, 1);
    dn += 32'(frame_done);
    step();
    dn += 32'(frame_done);
    chk("t2_done_cnt", dn, 1);
    chk("t2_idle", busy, 0);

    // test 3: abort at (2,1) with ready high
    pixel_ready = 1'b1;
    begin_frame();
    for (int i = 0; i < 6; i++) step();
    chk("t3_x_at", x_addr, 2);
    chk("t3_y_at", y_addr, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t3_pv", pixel_valid, 0);
    chk("t3_busy", busy, 0);
    chk("t3_x", x_addr, 0);
    chk("t3_y", y_addr, 0);
    chk("t3_winreq", win_req, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t3_nodone", frame_done, 0);
      step();
    end
    begin_frame();
    chk("t3_restart_x", x_addr, 0);
    chk("t3_restart_y", y_addr, 0);
    chk("t3_restart_fs", frame_start, 1);
    abort = 1'b1;
    step();
    chk("t3_abort2_busy", busy, 0);
    // abort in IDLE masks start
    start = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("t3_idle_abort", busy, 0);
    chk("t3_idle_abort_w", win_req, 0);

    // test 4: start held through SCAN and DONE
    pixel_ready = 1'b1;
    begin_frame();
    start = 1'b1;
    nx = 0;
    for (int i = 0; i < 12; i++) begin
      chk("t4_x", x_addr, i % 4);
      chk("t4_y", y_addr, i / 4);
      if (pixel_valid && pixel_ready) nx++;
      step();
    end
    chk("t4_xfers", nx, 12);
    chk("t4_done", frame_done, 1);
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_idle", busy, 0);
      chk("t4_idle_w", win_req, 0);
      step();
    end

    // test 5: async reset mid-row at (1,2)
    begin_frame();
    for (int i = 0; i < 9; i++) step();
    chk("t5_x_at", x_addr, 1);
    chk("t5_y_at", y_addr, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_pv", pixel_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_x", x_addr, 0);
    chk("t5_y", y_addr, 0);
    chk("t5_done", frame_done, 0);
    step();
    reset = 1'b0;
    pixel_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t5_idle", busy, 0);
      chk("t5_winreq", win_req, 0);
      chk("t5_nodone", frame_done, 0);
    end

    // test 6: default-size frame, ready always high
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    ack2 = 1'b1;
    step();
    ack2 = 1'b0;
    nx = 0; cyc = 0; maxx = 0; lx = -1; ly = -1;
    while (nx < 76800 && cyc < 80000) begin
      if (pv2 && ready2) begin
        nx++;
        lx = 32'(x2);
        ly = 32'(y2);
        if (32'(x2) > maxx) maxx = 32'(x2);
      end
      step();
      cyc++;
    end
    chk("t6_xfers", nx, 76800);
    chk("t6_last_x", lx, 239);
    chk("t6_last_y", ly, 319);
    chk("t6_max_x", maxx, 239);
    chk("t6_done", done2, 1);
    step();
    chk("t6_idle", busy2, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
